csr_access_unit: RTL
====================

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 SHALL have parameter CSR_BASE, default 12'h7C0, meaning the 12-bit address of CSR index 0; the window is 16 consecutive CSRs.
REQ-002 SHALL have parameter RO_MASK, default 16'h0003, meaning bit i set makes index i read-only (the hardware event counters).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, CSR instruction request valid.
REQ-006 SHALL have port req_ready, output, 1, the unit accepts a request.
REQ-007 SHALL have port req_funct3, input, 3, the Zicsr funct3 field.
REQ-008 SHALL have port req_addr, input, 12, the CSR address.
REQ-009 SHALL have port req_src, input, 32, the rs1 value; for immediate forms only bits [4:0] are used, as the zero-extended uimm.
REQ-010 SHALL have port req_src_nz, input, 1, the rs1 or uimm field is nonzero.
REQ-011 SHALL have port csr_raddr, output, 4, the read index to the CSR file.
REQ-012 SHALL have port csr_rdata, input, 32, the combinational read data from the CSR file.
REQ-013 SHALL have port csr_wen, output, 1, the CSR file write enable.
REQ-014 SHALL have port csr_waddr, output, 12, the CSR file write address.
REQ-015 SHALL have port csr_wdata, output, 32, the CSR file write data.
REQ-016 SHALL have port resp_valid, output, 1, a response is available.
REQ-017 SHALL have port resp_ready, input, 1, the consumer accepts the response.
REQ-018 SHALL have port resp_rdata, output, 32, the old CSR value to be written to rd.
REQ-019 SHALL have port resp_illegal, output, 1, the request was illegal.

Function
REQ-020 SHALL implement the FSM states IDLE, READ, WRITE and RESP; req_ready is 1 only in IDLE.
REQ-021 SHALL, in IDLE with req_valid=1, latch funct3, addr, src and src_nz, and go to READ.
REQ-022 SHALL, in READ, drive csr_raddr = latched addr[3:0], capture csr_rdata into resp_rdata, and compute the new value; csr_raddr is a don't-care in other states.
REQ-023 SHALL compute the new value from the funct3 low bits: 01 (RW/RWI) new = src; 10 (RS/RSI) new = old | src; 11 (RC/RCI) new = old & ~src; funct3[2]=1 selects src = {27'b0, uimm}.
REQ-024 SHALL set write_needed = 1 for RW/RWI, and req_src_nz for RS/RC/RSI/RCI.
REQ-025 SHALL treat as illegal: funct3 000 or 100; addr[11:4] != CSR_BASE[11:4]; or write_needed=1 while RO_MASK[addr[3:0]]=1.
REQ-026 SHALL, from READ, go to WRITE if write_needed and legal, otherwise go directly to RESP.
REQ-027 SHALL, in WRITE, assert csr_wen for exactly one cycle with csr_waddr = latched addr and csr_wdata = new value, then go to RESP.
REQ-028 SHALL, in RESP, hold resp_valid=1 and keep resp_rdata and resp_illegal stable until resp_ready=1, then return to IDLE in the next cycle.
REQ-029 SHALL use latency, with accept at edge T and resp_resp_ready held high: resp_valid at T+3 on the write path and at T+2 on the no-write or illegal path.
REQ-030 SHALL make resp_rdata for an illegal request 32'h0; a read-only RS/RC with src_nz=0 is legal and returns the counter value.
REQ-031 SHALL return in rd the value sampled in READ; counter increments between READ and WRITE are overwritten by the write (read-modify-write is not atomic with counters, by design).
REQ-032 SHALL not accept a new request until the RESP handshake completes; there is no back-to-back overlap.

Reset
REQ-033 SHALL, when rst=1 at an edge, force state IDLE, csr_wen=0, resp_valid=0, resp_rdata=0 and resp_illegal=0, regardless of the current state, including mid-WRITE and RESP.
REQ-034 SHALL assert req_ready=1 in the first cycle after rst deasserts.
REQ-035 SHALL complete no write if rst is asserted during READ.

Verification
REQ-036 SHALL verify CSRRW, addr 12'h7C5, src 32'hDEADBEEF, CSR old 32'h12345678 -> csr_wen pulse with waddr 7C5 and wdata DEADBEEF; resp_rdata 12345678; resp_illegal=0.
REQ-037 SHALL verify CSRRSI, addr 12'h7C4, uimm 5'h03, src_nz=1, old 32'hF0 -> wdata 32'hF3; CSRRCI uimm 5'h10 with old 32'hFF -> wdata 32'hEF.
REQ-038 SHALL verify CSRRS, addr 12'h7C0, src_nz=0 -> no csr_wen, resp_rdata equals counter, resp_illegal=0, resp_valid 2 cycles after accept.
REQ-039 SHALL verify CSRRW to 12'h7C1, funct3 000, and addr 12'h300 -> each gives no csr_wen, resp_illegal=1, resp_rdata=0.
REQ-040 SHALL verify resp_ready held 0 for 5 cycles -> resp_valid and data stable, req_ready=0, and a pending req_valid is not accepted.
REQ-041 SHALL verify rst asserted in READ and then in RESP -> no csr_wen, resp_valid=0 after the edge, req_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/csr_access_unit.sv
// csr_access_unit: steps one Zicsr instruction through read, an optional write, and a response handshake.
module csr_access_unit #(
  parameter logic [11:0] CSR_BASE = 12'h7C0,
  parameter logic [15:0] RO_MASK  = 16'h0003
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_src,
  input  logic        req_src_nz,
  output logic [3:0]  csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic        csr_wen,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_illegal
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned AW     = 12;
  localparam int unsigned IW     = 4;
  localparam int unsigned UIMM_W = 5;
  localparam int unsigned F3_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;

  logic [F3_W-1:0] r_funct3;
  logic [AW-1:0]   r_addr;
  logic [XLEN-1:0] r_src;
  logic            r_src_nz;
  logic [XLEN-1:0] r_wdata;
  logic            r_wen;
  logic            r_req_ready;
  logic            r_resp_valid;
  logic [XLEN-1:0] r_resp_rdata;
  logic            r_resp_illegal;

  logic [XLEN-1:0] w_src_eff;
  logic [XLEN-1:0] w_new;
  logic            w_write_needed;
  logic            w_illegal;
  logic            w_latch;
  logic            w_capture;
  logic            w_req_ready_nxt;
  logic            w_wen_nxt;
  logic            w_resp_valid_nxt;

  // Operand selection, new-value computation and legality of the latched request.
  always_comb begin
    w_src_eff      = r_funct3[2] ? XLEN'(r_src[UIMM_W-1:0]) : r_src;
    w_write_needed = (r_funct3[1:0] == 2'b01) | r_src_nz;
    w_illegal      = (r_funct3[1:0] == 2'b00)
                   | (r_addr[AW-1:IW] != CSR_BASE[AW-1:IW])
                   | (w_write_needed & RO_MASK[r_addr[IW-1:0]]);
    case (r_funct3[1:0])
      2'b01:   w_new = w_src_eff;
      2'b10:   w_new = csr_rdata | w_src_eff;
      default: w_new = csr_rdata & ~w_src_eff;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-value decode for the registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_latch     = 1'b1;
          w_state_nxt = READ;
        end
      end
      READ: begin
        w_capture   = 1'b1;
        w_state_nxt = (w_write_needed && !w_illegal) ? WRITE : RESP;
      end
      WRITE: begin
        w_state_nxt = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_req_ready_nxt  = (w_state_nxt == IDLE);
    w_wen_nxt        = (w_state_nxt == WRITE);
    w_resp_valid_nxt = (w_state_nxt == RESP);
  end

  // Request latch, read capture and registered handshake/write outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_funct3       <= '0;
      r_addr         <= '0;
      r_src          <= '0;
      r_src_nz       <= 1'b0;
      r_wdata        <= '0;
      r_wen          <= 1'b0;
      r_req_ready    <= 1'b1;
      r_resp_valid   <= 1'b0;
      r_resp_rdata   <= '0;
      r_resp_illegal <= 1'b0;
    end else begin
      r_req_ready  <= w_req_ready_nxt;
      r_wen        <= w_wen_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      if (w_latch) begin
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_src    <= req_src;
        r_src_nz <= req_src_nz;
      end
      if (w_capture) begin
        r_resp_rdata   <= w_illegal ? '0 : csr_rdata;
        r_resp_illegal <= w_illegal;
        r_wdata        <= w_new;
      end
    end
  end

  assign req_ready    = r_req_ready;
  assign csr_raddr    = r_addr[IW-1:0];
  assign csr_wen      = r_wen;
  assign csr_waddr    = r_addr;
  assign csr_wdata    = r_wdata;
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_resp_rdata;
  assign resp_illegal = r_resp_illegal;

endmodule
